// File: rtl/dds_symbol_feeder.sv
// Byte FIFO plus serialiser feeding a DDS modulator: 1-bit symbols (ASK/FSK/BPSK/RAW) or
// 2-bit symbols (QPSK), MSB first, each held for SYMBOL_CYCLES clocks.
module dds_symbol_feeder #(
  parameter longint unsigned FREQ_HI       = 5,
  parameter longint unsigned FREQ_LO       = 1,
  parameter longint unsigned FREQ_CLK      = 50_000_000,
  parameter int unsigned     SYMBOL_CYCLES = 5_000_000,
  parameter int unsigned     FIFO_DEPTH    = 4,
  parameter logic [3:0]      QPSK          = 4'b1100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mode,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [1:0]  sym_data,
  output logic [31:0] fsk_phase_inc,
  output logic        dds_en,
  output logic        sym_strobe,
  output logic        busy
);

  localparam logic [63:0] INC_HI_W = (64'(FREQ_HI) << 32) / 64'(FREQ_CLK);
  localparam logic [63:0] INC_LO_W = (64'(FREQ_LO) << 32) / 64'(FREQ_CLK);
  localparam logic [31:0] INC_HI   = INC_HI_W[31:0];
  localparam logic [31:0] INC_LO   = INC_LO_W[31:0];
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CW       = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYMBOL_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r, count_next_s;
  logic          in_ready_r;
  state_t        state_r;
  logic [7:0]    sh_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    nleft_r;
  logic          qpsk_r;
  logic          push_s, pop_s, empty_s, sym_end_s, last_sym_s;
  logic [1:0]    cur_sym_s;
  logic          load_qpsk_s;

  assign push_s      = in_valid & in_ready_r;
  assign empty_s     = (count_r == {(AW+1){1'b0}});
  assign sym_end_s   = (state_r == SEND) && (cnt_r == CNT_LAST);
  assign last_sym_s  = sym_end_s && (nleft_r == 4'd1);
  assign pop_s       = !empty_s && ((state_r == IDLE) || last_sym_s);
  assign cur_sym_s   = qpsk_r ? sh_r[7:6] : {1'b0, sh_r[7]};
  assign load_qpsk_s = (mode == QPSK);
  assign in_ready    = in_ready_r;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + (AW+1)'(1);
      2'b01:   count_next_s = count_r - (AW+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, no reset needed on payload
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      in_ready_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s != DEPTH_C);
    end
  end

  // Serialiser FSM; outputs are a registered view of the current symbol, one cycle behind
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= IDLE;
      sh_r          <= 8'h00;
      cnt_r         <= {CW{1'b0}};
      nleft_r       <= 4'd0;
      qpsk_r        <= 1'b0;
      sym_data      <= 2'b00;
      dds_en        <= 1'b0;
      sym_strobe    <= 1'b0;
      busy          <= 1'b0;
      fsk_phase_inc <= INC_LO;
    end else begin
      dds_en        <= (state_r == SEND);
      sym_data      <= (state_r == SEND) ? cur_sym_s : 2'b00;
      sym_strobe    <= (state_r == SEND) && (cnt_r == {CW{1'b0}});
      fsk_phase_inc <= ((state_r == SEND) && cur_sym_s[0]) ? INC_HI : INC_LO;
      busy          <= (state_r == SEND) || pop_s || (count_next_s != {(AW+1){1'b0}});
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_r <= SEND;
            sh_r    <= mem_r[rd_ptr_r];
            cnt_r   <= {CW{1'b0}};
            qpsk_r  <= load_qpsk_s;
            nleft_r <= load_qpsk_s ? 4'd4 : 4'd8;
          end
        end
        SEND: begin
          if (sym_end_s) begin
            cnt_r <= {CW{1'b0}};
            if (last_sym_s) begin
              // Next byte continues seamlessly so the strobe period never stretches
              if (pop_s) begin
                sh_r    <= mem_r[rd_ptr_r];
                qpsk_r  <= load_qpsk_s;
                nleft_r <= load_qpsk_s ? 4'd4 : 4'd8;
              end else begin
                state_r <= IDLE;
              end
            end else begin
              sh_r    <= qpsk_r ? {sh_r[5:0], 2'b00} : {sh_r[6:0], 1'b0};
              nleft_r <= nleft_r - 4'd1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
